// File: rtl/controle_multiciclo.sv
// Main control FSM of the multicycle RV32 subset core (lw, sw, addi, sub, xor, srl, beq).
// Sequences PC, IR, register file and the shared memory, drives the ALU control decoder,
// tolerates memory wait states up to a limit, traps on illegal instructions and counts
// retired instructions.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   instr              current IR contents
//   mem_ready          memory completes the current access this cycle
//   alu_zero           ALU zero flag, used by beq
//   alu_op, f3f7       to the ALU control decoder
//   alu_src_a/b        ALU operand selects
//   pc_write, pc_write_cond, pc_source   PC update controls
//   iord, mem_read, mem_write            shared memory controls
//   ir_write, mem_to_reg, reg_write      IR and register file controls
//   retired, instr_count                 retire pulse and wrapping retire counter
//   trap               sticky error flag (held until reset)
module controle_multiciclo #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic [1:0]       alu_op,
    output logic [3:0]       f3f7,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             retired,
    output logic [CNT_W-1:0] instr_count,
    output logic             trap
);

    localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr,
        StExecR, StExecI, StAluWb, StBranch, StTrap
    } state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q;
    logic [CNT_W-1:0]   instr_count_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       stall;
    logic       wait_hit;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign f3f7         = {instr[30], instr[14:12]};
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // Stall = a memory-facing state waiting on mem_ready; the limit cycle traps unless ready.
    assign stall    = (state_q == StFetch || state_q == StMemRd || state_q == StMemWr)
                      && !mem_ready;
    assign wait_hit = stall && (wait_cnt_q == WaitW'(WAIT_LIMIT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready)     state_d = StDecode;
                else if (wait_hit) state_d = StTrap;
            end
            StDecode: begin
                if (opcode == OpLoad || opcode == OpStore) begin
                    state_d = StMemAddr;
                end else if (opcode == OpRType &&
                             (funct3 == 3'b000 || funct3 == 3'b100 || funct3 == 3'b101)) begin
                    state_d = StExecR;
                end else if (opcode == OpIType && funct3 == 3'b000) begin
                    state_d = StExecI;
                end else if (opcode == OpBranch && funct3 == 3'b000) begin
                    state_d = StBranch;
                end else begin
                    state_d = StTrap;
                end
            end
            StMemAddr: state_d = (opcode == OpLoad) ? StMemRd : StMemWr;
            StMemRd: begin
                if (mem_ready)     state_d = StMemWb;
                else if (wait_hit) state_d = StTrap;
            end
            StMemWb:   state_d = StFetch;
            StMemWr: begin
                if (mem_ready)     state_d = StFetch;
                else if (wait_hit) state_d = StTrap;
            end
            StExecR:   state_d = StAluWb;
            StExecI:   state_d = StAluWb;
            StAluWb:   state_d = StFetch;
            StBranch:  state_d = StFetch;
            StTrap:    state_d = StTrap;
            default:   state_d = StTrap;
        endcase
    end

    always_comb begin
        alu_op        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        retired       = 1'b0;
        trap          = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            // Branch target computed early into ALUOut.
            StDecode:  alu_src_b = 2'b10;
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retired    = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retired   = mem_ready;
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StAluWb: begin
                reg_write = 1'b1;
                retired   = 1'b1;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_source     = 1'b1;
                pc_write_cond = alu_zero;
                retired       = 1'b1;
            end
            StTrap:  trap = 1'b1;
            default: trap = 1'b1;
        endcase
    end

    assign instr_count = instr_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StFetch;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_cnt_q <= '0;
            end else if (stall) begin
                wait_cnt_q <= wait_cnt_q + WaitW'(1);
            end
            if (retired) begin
                instr_count_q <= instr_count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized bench for controle_multiciclo: instructions of random class with random memory
// stall lengths; expected per-cycle control words come from the instruction-level phase list.
module tb_controle_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;

    logic [1:0]  alu_op, alu_src_b;
    logic [3:0]  f3f7;
    logic        alu_src_a, pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write;
    logic        ir_write, mem_to_reg, reg_write, retired, trap;
    logic [15:0] instr_count;

    logic [1:0]  d2_alu_op, d2_alu_src_b, d2_instr_count;
    logic [3:0]  d2_f3f7;
    logic        d2_alu_src_a, d2_pc_write, d2_pc_write_cond, d2_pc_source, d2_iord;
    logic        d2_mem_read, d2_mem_write, d2_ir_write, d2_mem_to_reg, d2_reg_write;
    logic        d2_retired, d2_trap;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;

    always #5 clk = ~clk;

    controle_multiciclo #(.WAIT_LIMIT(15), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .alu_op(alu_op), .f3f7(f3f7), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retired(retired),
        .instr_count(instr_count), .trap(trap)
    );

    controle_multiciclo #(.WAIT_LIMIT(15), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .alu_op(d2_alu_op), .f3f7(d2_f3f7), .alu_src_a(d2_alu_src_a),
        .alu_src_b(d2_alu_src_b), .pc_write(d2_pc_write), .pc_write_cond(d2_pc_write_cond),
        .pc_source(d2_pc_source), .iord(d2_iord), .mem_read(d2_mem_read),
        .mem_write(d2_mem_write), .ir_write(d2_ir_write), .mem_to_reg(d2_mem_to_reg),
        .reg_write(d2_reg_write), .retired(d2_retired), .instr_count(d2_instr_count),
        .trap(d2_trap)
    );

    logic [15:0] ctl;
    assign ctl = {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source, iord,
                  mem_read, mem_write, ir_write, mem_to_reg, reg_write, retired, trap};

    function automatic logic [15:0] cw(logic [1:0] op, logic sa, logic [1:0] sb, logic pcw,
                                       logic pcwc, logic pcs, logic io, logic mr, logic mw,
                                       logic irw, logic m2r, logic rw, logic ret, logic tr);
        return {op, sa, sb, pcw, pcwc, pcs, io, mr, mw, irw, m2r, rw, ret, tr};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs low-phase, compare, advance; entered and left at negedge.
    task automatic step(input string tag, input logic [15:0] exp, input logic rdy,
                        input logic az);
        mem_ready = rdy;
        alu_zero  = az;
        #1;
        check({tag, ".ctl"}, {16'h0, ctl}, {16'h0, exp});
        check({tag, ".cnt"}, {16'h0, instr_count}, cnt % 65536);
        check({tag, ".cnt2"}, {30'h0, d2_instr_count}, cnt % 4);
        check({tag, ".f3f7"}, {28'h0, f3f7}, {28'h0, instr[30], instr[14:12]});
        @(posedge clk);
        if (exp[1]) cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt   = 0;
    endtask

    function automatic int pick_stall();
        int r = $urandom_range(0, 99);
        if (r < 3) return 15 + $urandom_range(0, 2);
        if (r < 7) return 14;
        return $urandom_range(0, 3);
    endfunction

    // Memory phase: `stalls` not-ready cycles, then one ready cycle, unless the limit is hit.
    task automatic mem_phase(input string tag, input logic [15:0] wait_w,
                             input logic [15:0] done_w, input int stalls, output bit trapped);
        trapped = 0;
        for (int i = 0; i < stalls && i < 15; i++) step(tag, wait_w, 1'b0, 1'($urandom));
        if (stalls >= 15) trapped = 1;
        else step(tag, done_w, 1'b1, 1'($urandom));
    endtask

    task automatic trap_tail();
        logic [15:0] tw = cw(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        int n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) step("trap", tw, 1'($urandom), 1'($urandom));
        do_reset();
    endtask

    task automatic run_one();
        int          kind = $urandom_range(0, 11);
        logic [31:0] ins  = $urandom;
        logic [2:0]  f3;
        logic        az;
        bit          tr;
        logic [15:0] fetch_w = cw(2'b00, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        logic [15:0] fetch_r = cw(2'b00, 0, 2'b01, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        logic [15:0] dec_w   = cw(2'b00, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        logic [15:0] ma_w    = cw(2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        logic [15:0] mr_w    = cw(2'b00, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        logic [15:0] wb_w    = cw(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        logic [15:0] mw_w    = cw(2'b00, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        logic [15:0] mw_r    = cw(2'b00, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        logic [15:0] er_w    = cw(2'b10, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        logic [15:0] ei_w    = cw(2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        logic [15:0] awb_w   = cw(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        case (kind)
            0:       ins[6:0] = 7'b0000011;
            1:       ins[6:0] = 7'b0100011;
            2, 3, 4: begin
                ins[6:0] = 7'b0110011;
                f3 = (kind == 2) ? 3'b000 : (kind == 3) ? 3'b100 : 3'b101;
                ins[14:12] = f3;
            end
            5:       begin ins[6:0] = 7'b0010011; ins[14:12] = 3'b000; end
            6, 7:    begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b000; end
            8:       ins[6:0] = 7'b0110111;
            9: begin
                ins[6:0] = 7'b0110011;
                f3 = 3'($urandom_range(1, 3));
                ins[14:12] = ($urandom_range(0, 1) == 1) ? f3 : 3'($urandom_range(6, 7));
            end
            10: begin
                ins[6:0] = ($urandom_range(0, 1) == 1) ? 7'b0010011 : 7'b1100011;
                ins[14:12] = 3'($urandom_range(1, 7));
            end
            default: ins[6:0] = 7'b1111111;
        endcase
        instr = ins;
        mem_phase("fetch", fetch_w, fetch_r, pick_stall(), tr);
        if (tr) begin trap_tail(); return; end
        step("decode", dec_w, 1'($urandom), 1'($urandom));
        case (kind)
            0: begin
                step("lw.addr", ma_w, 1'($urandom), 1'($urandom));
                mem_phase("lw.rd", mr_w, mr_w, pick_stall(), tr);
                if (tr) begin trap_tail(); return; end
                step("lw.wb", wb_w, 1'($urandom), 1'($urandom));
            end
            1: begin
                step("sw.addr", ma_w, 1'($urandom), 1'($urandom));
                mem_phase("sw.wr", mw_w, mw_r, pick_stall(), tr);
                if (tr) begin trap_tail(); return; end
            end
            2, 3, 4: begin
                step("r.exec", er_w, 1'($urandom), 1'($urandom));
                step("r.wb", awb_w, 1'($urandom), 1'($urandom));
            end
            5: begin
                step("i.exec", ei_w, 1'($urandom), 1'($urandom));
                step("i.wb", awb_w, 1'($urandom), 1'($urandom));
            end
            6, 7: begin
                az = 1'($urandom);
                step("beq", cw(2'b01, 1, 2'b00, 0, az, 1, 0, 0, 0, 0, 0, 0, 1, 0),
                     1'($urandom), az);
            end
            default: trap_tail();
        endcase
    endtask

    initial begin
        bit tr;
        // Reset mid-lw: stalled in the read phase, then reset lands back in fetch.
        do_reset();
        instr = 32'h0001_2083;  // lw x1,0(x2)
        step("rst.fetch", cw(2'b00, 0, 2'b01, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b1, 1'b0);
        step("rst.dec", cw(2'b00, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
        step("rst.ma", cw(2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
        mem_phase("rst.mr", cw(2'b00, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0),
                  cw(2'b00, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 3, tr);
        step("rst.wb", cw(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), 1'b0, 1'b0);
        step("rst.fetch2", cw(2'b00, 0, 2'b01, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b1, 1'b0);
        step("rst.dec2", cw(2'b00, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
        step("rst.ma2", cw(2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
        step("rst.mr2", cw(2'b00, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        do_reset();
        step("rst.after", cw(2'b00, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        do_reset();
        for (int n = 0; n < 400; n++) run_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
